// File: rtl/pc_fetch_controller.sv
// Fetch-stage program counter sequencer for the RV64 pipeline.
// It picks the next PC each cycle: sequential step, hazard hold, EX redirect or halt.
// It also drives the flush and misalign pulses and fetch-valid qualification.
// It presents RESET_PC once after reset and stops fetch at END_PC.
module pc_fetch_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned INSTR_BYTES = 4,
    parameter logic [63:0] END_PC      = 64'd64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [63:0]      redirect_target_i,
    input  logic             halt_req_i,
    output logic [63:0]      pc_o,
    output logic [63:0]      pc_plus4_o,
    output logic             fetch_valid_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             misalign_o,
    output logic             halted_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam int unsigned XLEN = 64;
    localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

    typedef enum logic [2:0] {
        ST_BOOT  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              valid_q, valid_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   tgt_pc;
    logic [CNT_W-1:0]  count_inc;

    assign seq_pc    = pc_q + STEP;
    assign tgt_pc    = {redirect_target_i[XLEN-1:2], 2'b00};
    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

    // State and registered-output update; reset drops everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    // Next-state and next-output selection: halt > redirect > stall > sequential.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        halted_d   = halted_q;
        count_d    = count_q;

        case (state_q)
            ST_BOOT: begin
                // RESET_PC is already on pc_o; qualify it as the first fetch.
                valid_d = 1'b1;
                count_d = CNT_W'(1);
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (halt_req_i) begin
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (redirect_i) begin
                    flush_d    = 1'b1;
                    misalign_d = |redirect_target_i[1:0];
                    if (tgt_pc == END_PC) begin
                        pc_d     = END_PC;
                        state_d  = ST_HALT;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        pc_d    = tgt_pc;
                        state_d = ST_FLUSH;
                        count_d = count_inc;
                    end
                end else if (stall_i) begin
                    state_d = ST_STALL;
                end else if (seq_pc == END_PC) begin
                    pc_d     = END_PC;
                    state_d  = ST_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else begin
                    pc_d    = seq_pc;
                    state_d = ST_RUN;
                    count_d = count_inc;
                end
            end
            ST_HALT: begin
                // Absorbing until reset.
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    assign pc_o          = pc_q;
    assign pc_plus4_o    = pc_q + STEP;
    assign fetch_valid_o = valid_q;
    assign flush_if_id_o = flush_q;
    assign flush_id_ex_o = flush_q;
    assign misalign_o    = misalign_q;
    assign halted_o      = halted_q;
    assign state_o       = state_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Self-checking bench for pc_fetch_controller: directed scenarios plus random traffic
// compared against a behavioural fetch model.
module tb_pc_fetch_controller;

    localparam longint unsigned END_ADDR = 64'd64;
    localparam longint unsigned CNT_MAX  = 64'hFFFF_FFFF;
    localparam int BOOT = 0, RUN = 1, STALL = 2, FLUSH = 3, HALT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall_i = 1'b0, redirect_i = 1'b0, halt_req_i = 1'b0;
    logic [63:0] redirect_target_i = '0;
    logic [63:0] pc_o, pc_plus4_o;
    logic        fetch_valid_o, flush_if_id_o, flush_id_ex_o, misalign_o, halted_o;
    logic [2:0]  state_o;
    logic [31:0] fetch_count_o;

    // Second instance for the address-wrap case; its inputs stay idle.
    logic        w_reset = 1'b0;
    logic        w_idle = 1'b0;
    logic [63:0] w_tgt = '0;
    logic [63:0] w_pc, w_pc4;
    logic        w_valid, w_fl1, w_fl2, w_mis, w_halted;
    logic [2:0]  w_state;
    logic [31:0] w_count;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    longint unsigned m_pc, m_cnt;
    bit m_valid, m_halted, m_fl, m_mis;
    int m_state;

    always #5 clk = ~clk;

    pc_fetch_controller dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_target_i(redirect_target_i), .halt_req_i(halt_req_i),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .fetch_valid_o(fetch_valid_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .misalign_o(misalign_o), .halted_o(halted_o), .state_o(state_o),
        .fetch_count_o(fetch_count_o)
    );

    pc_fetch_controller #(
        .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .INSTR_BYTES(4), .END_PC(64'd0), .CNT_W(32)
    ) dut_wrap (
        .clk(clk), .reset(w_reset), .stall_i(w_idle), .redirect_i(w_idle),
        .redirect_target_i(w_tgt), .halt_req_i(w_idle),
        .pc_o(w_pc), .pc_plus4_o(w_pc4), .fetch_valid_o(w_valid),
        .flush_if_id_o(w_fl1), .flush_id_ex_o(w_fl2),
        .misalign_o(w_mis), .halted_o(w_halted), .state_o(w_state),
        .fetch_count_o(w_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 64'd0; m_cnt = 0; m_valid = 0; m_halted = 0;
        m_fl = 0; m_mis = 0; m_state = BOOT;
    endfunction

    // One clock edge of the fetch behaviour, written from the priority rules.
    function automatic void model_edge(bit st, bit rd, logic [63:0] tg, bit hr);
        longint unsigned want;
        m_fl = 0; m_mis = 0;
        if (m_state == BOOT) begin
            m_valid = 1; m_cnt = 1; m_state = RUN; return;
        end
        if (m_state == HALT) return;
        if (hr) begin
            m_state = HALT; m_valid = 0; m_halted = 1; return;
        end
        if (rd) begin
            want = (tg / 4) * 4;
            m_fl = 1;
            m_mis = (tg % 4) != 0;
        end else if (st) begin
            m_state = STALL; return;
        end else begin
            want = m_pc + 4;
        end
        if (want == END_ADDR) begin
            m_pc = END_ADDR; m_state = HALT; m_valid = 0; m_halted = 1; return;
        end
        m_pc = want;
        if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1;
        m_state = rd ? FLUSH : RUN;
    endfunction

    task automatic compare_all(input string tag);
        chk({tag, ".pc"},     pc_o, m_pc);
        chk({tag, ".pc4"},    pc_plus4_o, m_pc + 4);
        chk({tag, ".valid"},  64'(fetch_valid_o), 64'(m_valid));
        chk({tag, ".flifid"}, 64'(flush_if_id_o), 64'(m_fl));
        chk({tag, ".flidex"}, 64'(flush_id_ex_o), 64'(m_fl));
        chk({tag, ".mis"},    64'(misalign_o), 64'(m_mis));
        chk({tag, ".halted"}, 64'(halted_o), 64'(m_halted));
        chk({tag, ".state"},  64'(state_o), 64'(m_state));
        chk({tag, ".count"},  64'(fetch_count_o), m_cnt);
    endtask

    // Called at a negedge: drive inputs, take the edge, compare at the next negedge.
    task automatic tick(input string tag, input bit st, input bit rd,
                        input logic [63:0] tg, input bit hr);
        stall_i = st; redirect_i = rd; redirect_target_i = tg; halt_req_i = hr;
        @(posedge clk);
        model_edge(st, rd, tg, hr);
        @(negedge clk);
        compare_all(tag);
    endtask

    // Called at a negedge: reset for one cycle, release before the next edge.
    task automatic do_reset();
        stall_i = 0; redirect_i = 0; redirect_target_i = '0; halt_req_i = 0;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        @(negedge clk);
        compare_all("rst_hold");
        reset = 1'b1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag, 0, 0, '0, 0);
    endtask

    initial begin
        @(negedge clk);

        // Plain run from reset to program end.
        do_reset();
        tick("boot", 0, 0, '0, 0);
        chk("boot_pc", pc_o, 64'd0);
        chk("boot_count", 64'(fetch_count_o), 64'd1);
        idle("seq", 15);
        chk("seq60", pc_o, 64'd60);
        tick("end", 0, 0, '0, 0);
        chk("end_pc", pc_o, 64'd64);
        chk("end_halted", 64'(halted_o), 64'd1);
        chk("end_valid", 64'(fetch_valid_o), 64'd0);
        chk("end_count", 64'(fetch_count_o), 64'd16);
        idle("halted", 3);

        // Stall at pc 8, then redirect with stall at pc 20.
        do_reset();
        idle("pre", 3);
        for (int i = 0; i < 3; i++) tick("stall", 1, 0, '0, 0);
        chk("stall_pc", pc_o, 64'd8);
        chk("stall_state", 64'(state_o), 64'd2);
        chk("stall_count", 64'(fetch_count_o), 64'd3);
        tick("unstall", 0, 0, '0, 0);
        chk("unstall_pc", pc_o, 64'd12);
        idle("to20", 2);
        tick("redir", 1, 1, 64'h6, 0);
        chk("redir_pc", pc_o, 64'h4);
        chk("redir_flush", 64'(flush_if_id_o & flush_id_ex_o), 64'd1);
        chk("redir_mis", 64'(misalign_o), 64'd1);
        chk("redir_state", 64'(state_o), 64'd3);
        tick("postflush", 0, 0, '0, 0);
        chk("postflush_state", 64'(state_o), 64'd1);
        chk("postflush_pc", pc_o, 64'd8);

        // Halt beats redirect at pc 12; later redirects ignored.
        do_reset();
        idle("pre", 4);
        tick("halt", 0, 1, 64'd40, 1);
        chk("halt_pc", pc_o, 64'd12);
        chk("halt_flush", 64'(flush_if_id_o), 64'd0);
        chk("halt_state", 64'(state_o), 64'd4);
        tick("halt_redir", 0, 1, 64'd40, 0);
        chk("halt_redir_pc", pc_o, 64'd12);

        // Redirect straight to END_PC halts but still flushes.
        do_reset();
        idle("pre", 2);
        tick("redir_end", 0, 1, 64'd65, 0);
        chk("redir_end_halted", 64'(halted_o), 64'd1);
        chk("redir_end_flush", 64'(flush_id_ex_o), 64'd1);

        // Reset pulse in the middle of a flush cycle at pc 32.
        do_reset();
        idle("pre", 8);
        tick("fl32", 0, 1, 64'd32, 0);
        chk("fl32_flush", 64'(flush_if_id_o), 64'd1);
        #2;
        stall_i = 0; redirect_i = 0; redirect_target_i = '0; halt_req_i = 0;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("async");
        chk("async_pc", pc_o, 64'd0);
        chk("async_flush", 64'(flush_id_ex_o), 64'd0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        model_edge(0, 0, '0, 0);
        @(negedge clk);
        compare_all("reboot");
        chk("reboot_count", 64'(fetch_count_o), 64'd1);

        // Address wrap on the second instance.
        w_reset = 1'b1;
        @(negedge clk);
        chk("w_boot_pc", w_pc, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("w_boot_valid", 64'(w_valid), 64'd1);
        @(negedge clk);
        chk("w_pc2", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_pc4", w_pc4, 64'd0);
        chk("w_count2", 64'(w_count), 64'd2);
        @(negedge clk);
        chk("w_wrap_pc", w_pc, 64'd0);
        chk("w_wrap_halted", 64'(w_halted), 64'd1);
        chk("w_wrap_state", 64'(w_state), 64'd4);
        chk("w_wrap_count", 64'(w_count), 64'd2);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit st, rd, hr;
            logic [63:0] tg;
            st = ($urandom % 4) == 0;
            rd = ($urandom % 8) == 0;
            hr = ($urandom % 120) == 0;
            if (($urandom % 8) == 0) tg = {$urandom, $urandom};
            else tg = 64'($urandom_range(0, 80));
            tick("rnd", st, rd, tg, hr);
            if (m_state == HALT && ($urandom % 4) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Sequences the fetch-stage program counter of the pipelined RV64 core.
- Each cycle, selects the next PC from: sequential increment, hold (hazard stall), branch/jump redirect from EX, or halt.
- Generates pipeline flush pulses and fetch-valid qualification.
- Guarantees that RESET_PC is fetched exactly once after reset release, and stops fetch cleanly at program end.

Parameters:
RESET_PC, 64'd0, PC value loaded on reset and presented on the first fetch
INSTR_BYTES, 4, sequential increment step in bytes
END_PC, 64'd64, PC at which fetch stops (program end, e.g. after the bubble-sort image)
CNT_W, 32, width of the fetch counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
stall_i  input  1  hazard-unit stall; hold the current PC
redirect_i  input  1  taken branch/jump resolved in EX
redirect_target_i  input  64  redirect destination address
halt_req_i  input  1  external or ecall halt request
pc_o  output  64  current fetch address to instruction memory
pc_plus4_o  output  64  pc_o + INSTR_BYTES (combinational, for link register)
fetch_valid_o  output  1  pc_o carries a fetch to be consumed by IF/ID
flush_if_id_o  output  1  one-cycle pulse: squash IF/ID register
flush_id_ex_o  output  1  one-cycle pulse: squash ID/EX register
misalign_o  output  1  one-cycle pulse: redirect target had bits[1:0] != 0
halted_o  output  1  controller is in HALT
state_o  output  3  encoded FSM state (BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4)
fetch_count_o  output  CNT_W  number of distinct PCs presented since reset

Behaviour:
- Reset (reset==0, asynchronous), outputs:
  - pc_o=RESET_PC, fetch_valid_o=0, state_o=BOOT.
  - all pulses=0, halted_o=0, fetch_count_o=0.
- Reset deassertion is seen at the next rising edge only; no negedge-reset logic.
- BOOT:
  - At the first rising edge with reset==1: pc_o stays RESET_PC, fetch_valid_o<=1, fetch_count_o<=1, go to RUN.
  - RESET_PC is therefore presented for at least one full valid cycle.
- RUN/STALL next-PC priority at each edge (highest first): halt_req_i > redirect_i > stall_i > sequential.
- halt_req_i:
  - go to HALT; pc_o holds; fetch_valid_o<=0; halted_o<=1.
- redirect_i:
  - pc_o <= {redirect_target_i[63:2],2'b00}.
  - flush_if_id_o and flush_id_ex_o pulse 1 for exactly the next cycle.
  - Go to FLUSH.
  - misalign_o pulses the same cycle if target[1:0]!=0.
  - fetch_count_o += 1.
  - Overrides stall_i.
- stall_i (no redirect):
  - pc_o holds, fetch_valid_o stays 1, state STALL, fetch_count_o unchanged.
  - Leave STALL to RUN on the first edge with stall_i==0, which also performs that edge's sequential increment.
- Sequential:
  - pc_o <= pc_o + INSTR_BYTES, modulo 2^64 (wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0, no error).
  - fetch_count_o += 1.
- FLUSH: lasts one cycle (pulses high), then applies the same priority rules as RUN. A back-to-back redirect re-enters FLUSH and re-pulses.
- End of program:
  - When an edge in RUN/FLUSH would present a PC equal to END_PC, go to HALT instead.
  - pc_o <= END_PC, fetch_valid_o <= 0, halted_o <= 1.
  - A redirect to END_PC also halts (flush pulses still issued).
- HALT: absorbing state. All inputs ignored; pc_o held; exit only via reset.
- fetch_count_o saturates at all-ones.
- Reset asserted mid-operation (any state, including a flush pulse cycle): immediately returns all outputs to reset values; pulses drop the same instant.

Test Plan:
- Release reset, no stalls/redirects: pc_o sequence 0,4,8,… with 0 valid for one cycle after BOOT; at pc 60→64 halted_o=1, fetch_valid_o=0, fetch_count_o=16.
- At pc_o=8, stall_i high for 3 cycles: pc_o stays 8 for 4 cycles total, state_o=2, count frozen; then 12.
- At pc_o=20, assert redirect_i with target 0x06 and stall_i=1: pc_o=0x04, both flush pulses high one cycle, misalign_o=1, state FLUSH then RUN.
- Assert halt_req_i together with redirect_i at pc_o=12: HALT, pc_o=12, no flush pulses; later redirects ignored.
- END_PC=0, RESET_PC=64'hFFFF_FFFF_FFFF_FFF8: sequence FFF8, FFFC, then wrap to 0 → HALT at pc 0.
- Drop reset for a partial cycle during a flush pulse at pc 32: outputs immediately pc_o=0, pulses 0, count 0; re-release restarts at BOOT.
